// File: rtl/c_rr_arbiter_lock.sv
// Round-robin arbiter with packet lock: a granted requester holds the resource
// until it presents tail; priority rotates past the last packet's owner.
module c_rr_arbiter_lock #(
  parameter int num_req = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               update,
  input  logic [0:num_req-1] req,
  input  logic [0:num_req-1] tail,
  output logic [0:num_req-1] gnt,
  output logic               gnt_valid,
  output logic               locked
);

  logic [0:num_req-1] prio_q;
  logic [0:num_req-1] owner_q;
  logic               locked_q;

  logic [0:num_req-1] mask;
  logic [0:num_req-1] hi;
  logic [0:num_req-1] prio_rot;
  logic               seen;

  function automatic logic [0:num_req-1] first_set(input logic [0:num_req-1] v);
    logic [0:num_req-1] r;
    r = '0;
    for (int i = num_req - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Thermometer expansion of the one-hot pointer: ones from the pointer upward.
  always_comb begin
    mask = '0;
    seen = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      seen    = seen | prio_q[i];
      mask[i] = seen;
    end
    hi = req & mask;
  end

  always_comb begin
    if (!reset)
      gnt = '0;
    else if (locked_q)
      gnt = owner_q & req;
    else if (|hi)
      gnt = first_set(hi);
    else
      gnt = first_set(req);
  end

  assign gnt_valid = |gnt;
  assign locked    = locked_q;

  always_comb begin
    prio_rot = '0;
    for (int i = 0; i < num_req; i++)
      prio_rot[(i + 1) % num_req] = gnt[i];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q   <= {1'b1, {(num_req - 1){1'b0}}};
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else if (update && gnt_valid) begin
      if (|(gnt & tail)) begin
        prio_q   <= prio_rot;
        locked_q <= 1'b0;
        owner_q  <= '0;
      end else begin
        locked_q <= 1'b1;
        owner_q  <= gnt;
      end
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_subset  : assert property (@(posedge clk) (gnt & ~req) == '0);
  a_prio_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot(prio_q));
  a_owner_lock  : assert property (@(posedge clk) disable iff (!reset)
                                   $onehot(owner_q) == locked_q);

endmodule

// File: tb/tb_c_rr_arbiter_lock.sv
// Scoreboard bench for c_rr_arbiter_lock: directed scenarios plus random traffic
// checked against a circular-search reference model.
module tb_c_rr_arbiter_lock;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         update = 1'b0;
  logic [0:N-1] req = '0;
  logic [0:N-1] tail = '0;
  logic [0:N-1] gnt;
  logic         gnt_valid;
  logic         locked;

  c_rr_arbiter_lock #(.num_req(N)) dut (
    .clk(clk), .reset(reset), .update(update), .req(req), .tail(tail),
    .gnt(gnt), .gnt_valid(gnt_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: pointer index, lock flag, owner index.
  int m_prio = 0;
  bit m_locked = 1'b0;
  int m_owner = 0;

  typedef struct {
    logic [0:N-1] g;
    logic         l;
    bit           has_lit;
    logic [0:N-1] lit;
    int           step;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   fails = 0;
  int   step = 0;

  function automatic int model_pick(input logic [0:N-1] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_prio + k) % N]) return (m_prio + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int s);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, s, act, exp);
    end
  endtask

  task automatic cyc(input logic [0:N-1] r, input logic [0:N-1] t, input logic u,
                     input logic rs, input bit hl, input logic [0:N-1] lit);
    exp_t e;
    int p;
    logic [0:N-1] gv;
    req = r; tail = t; update = u; reset = rs;
    p = rs ? model_pick(r) : -1;
    gv = '0;
    if (p >= 0) gv[p] = 1'b1;
    e.g = gv; e.l = m_locked; e.has_lit = hl; e.lit = lit; e.step = step;
    sb.push_back(e);
    @(posedge clk);
    if (!rs) begin
      m_prio = 0; m_locked = 1'b0; m_owner = 0;
    end else if (u && p >= 0) begin
      if (t[p]) begin
        m_prio = (p + 1) % N; m_locked = 1'b0;
      end else begin
        m_locked = 1'b1; m_owner = p;
      end
    end
    step++;
    #1;
  endtask

  task automatic c(input logic [0:N-1] r, input logic [0:N-1] t, input logic u, input logic rs);
    cyc(r, t, u, rs, 1'b0, '0);
  endtask

  task automatic cl(input logic [0:N-1] r, input logic [0:N-1] t, input logic u,
                    input logic rs, input logic [0:N-1] lit);
    cyc(r, t, u, rs, 1'b1, lit);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("gnt", 32'(gnt), 32'(me.g), me.step);
      chk("gnt_valid", 32'(gnt_valid), 32'(|me.g), me.step);
      chk("locked", 32'(locked), 32'(me.l), me.step);
      if (me.has_lit) chk("gnt_plan", 32'(gnt), 32'(me.lit), me.step);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [0:N-1] rr, tt;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single-flit rotation
    cl(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000);
    cl(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000);
    cl(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100);
    cl(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010);
    cl(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001);
    cl(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000);

    // Multi-flit lock then release
    cl(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
    cl(4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100);
    repeat (3) cl(4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100);
    cl(4'b0101, 4'b0100, 1'b1, 1'b1, 4'b0100);
    cl(4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0001);

    // Owner bubble while locked
    c(4'b0000, 4'b0000, 1'b0, 1'b0);
    cl(4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100);
    repeat (2) cl(4'b1010, 4'b1111, 1'b1, 1'b1, 4'b0000);
    cl(4'b1110, 4'b0100, 1'b1, 1'b1, 4'b0100);

    // Pointer wrap
    c(4'b0000, 4'b0000, 1'b0, 1'b0);
    cl(4'b0010, 4'b1111, 1'b1, 1'b1, 4'b0010);
    cl(4'b1001, 4'b1111, 1'b1, 1'b1, 4'b0001);
    cl(4'b1001, 4'b1111, 1'b1, 1'b1, 4'b1000);

    // No commit without update
    c(4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (3) cl(4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1000);
    cl(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000);
    cl(4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100);

    // Reset mid-packet
    c(4'b0000, 4'b0000, 1'b0, 1'b0);
    cl(4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010);
    cl(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000);
    cl(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1000);

    for (int i = 0; i < 2000; i++) begin
      rr = N'($urandom);
      tt = N'($urandom) & N'($urandom);
      c(rr, tt, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0, step);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/c_rr_arbiter_lock.md
Name: c_rr_arbiter_lock

Overview:
- Round-robin arbiter with packet lock. Shares one resource among num_req requesters, e.g. a switch output port or VC allocator stage.
- Priority is held as a one-hot pointer. The pointer is expanded into a thermometer mask, the same way as the library's one-hot-to-thermometer converter, to split requests into a high-priority half and a wrap-around half.
- A granted requester keeps the resource until it signals tail. Pointer and lock state are registered; the grant is combinational from state and requests.

Parameters:
- num_req, 8, number of requesters; must be >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset; state is cleared on a clk edge with reset==0.
- update  input  1  commit enable; state changes only in cycles with update==1 and gnt_valid==1.
- req  input  [0:num_req-1]  request vector; index 0 is the leftmost bit.
- tail  input  [0:num_req-1]  per-requester "this transfer ends the packet" flag; sampled only for the granted index.
- gnt  output  [0:num_req-1]  one-hot grant, or all-zero.
- gnt_valid  output  1  OR-reduction of gnt.
- locked  output  1  registered; 1 while a packet holds the resource.

Behaviour:
- State registers:
  - prio_q [0:num_req-1], one-hot, the highest-priority index.
  - locked_q.
  - owner_q [0:num_req-1], one-hot, the lock holder.
- Reset (reset==0 at a clk edge): prio_q=bit 0 set; locked_q=0; owner_q=0.
- While reset==0, gnt=0 and gnt_valid=0 combinationally. locked reads 0 from the cycle after the reset edge.
- Mask: mask[i]=1 iff i >= index of prio_q. This is the thermometer expansion of prio_q, so prio_q=bit 0 gives an all-ones mask.
- Unlocked grant (locked_q==0):
  - hi = req & mask.
  - If hi != 0, gnt = lowest-index set bit of hi.
  - Else gnt = lowest-index set bit of req.
  - If req == 0, gnt = 0.
- Locked grant (locked_q==1): gnt = owner_q & req. If the owner drops req, gnt = 0 (bubble). No other requester may be granted while locked.
- Latency: gnt depends combinationally on req in the same cycle, with zero latency. State updates at the next clk edge.
- Update when update==1, gnt_valid==1 and reset==1:
  - If |(gnt & tail): prio_q <= gnt rotated by one toward the higher index (bit num_req-1 wraps to bit 0); locked_q <= 0; owner_q <= 0.
  - Else: locked_q <= 1; owner_q <= gnt; prio_q unchanged.
- If update==0 or gnt_valid==0, all state holds. A granted but uncommitted request does not advance priority.
- Single-flit packet (tail set on the first grant): the lock is never set and the pointer advances immediately.
- Wrap: a grant at index num_req-1 with tail makes index 0 the highest priority next cycle.
- Reset mid-packet: the lock is dropped and the pointer returns to index 0. No grant is issued in the reset cycle.
- tail bits of non-granted requesters are ignored.
- Invariants (to be asserted):
  - gnt is zero or one-hot and is a subset of req.
  - prio_q is always one-hot.
  - owner_q is one-hot iff locked_q.

Test Plan:
- Reset, then req=1111 and tail=1111 with update=1 for 5 cycles (num_req=4) -> gnt sequence 1000, 0100, 0010, 0001, 1000; locked stays 0.
- After reset, req=0101 and tail=0000, update=1 -> gnt=0100, locked=1 next cycle. gnt stays 0100 for 3 cycles while req=0101. Then tail=0100 -> unlock; next gnt=0001.
- Locked on index 1, owner drops req (req=1010) for 2 cycles -> gnt=0000 and gnt_valid=0, locked stays 1. Owner re-requests -> gnt=0100 again.
- prio at index 3 (after a grant to index 2 with tail), req=1001, tail=1111 -> gnt=0001, then prio wraps to index 0 -> next gnt=1000.
- req=1111 with update=0 for 3 cycles -> gnt constant 1000, prio_q and locked unchanged; the first update=1 cycle then advances to 0100.
- Locked on index 2, assert reset=0 for one cycle with req=1111 -> gnt=0000 during reset. Next cycle locked=0 and gnt=1000.
